// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: register map, register index type and CAUSE layout shared by the trap controller
package trap_ctrl_pkg;
  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h2;
  localparam logic [3:0] OFF_MODE  = 4'h4;
  localparam logic [3:0] OFF_CAUSE = 4'h6;
  localparam logic [3:0] OFF_GIE   = 4'h8;
  localparam int CAUSE_VALID = 15;
  localparam int MAX_SRC = 16;
  typedef enum logic [2:0] {R_PEND, R_MASK, R_MODE, R_CAUSE, R_GIE} reg_idx_t;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: lowest-index-wins priority encoder over N request bits
module trap_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [3:0]   id
);
  // scan from the top down so the lowest set index is the last to write id
  always_comb begin
    any = |req;
    id = 4'h0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) id = 4'(i);
  end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: N-source trap controller with pending/mask/mode/cause/gie registers on the core bus
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [15:0] ADDR_BASE = 16'hFF00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq,
  output logic             trap,
  input  logic             trap_ack,
  input  logic             mem_valid,
  input  logic [15:0]      mem_addr,
  input  logic [1:0]       mem_wstrb,
  input  logic [15:0]      mem_wdata,
  output logic [15:0]      mem_rdata,
  output logic             mem_ready
);
  typedef enum logic {S_IDLE, S_RESP} state_t;
  state_t state;
  logic [N_SRC-1:0] pend_e, prev, mask, mode, pend, active, rise, w1c;
  logic [15:0] off, wm, wv, mask_w, mode_w, rd_val, cause;
  logic sel, go, we, gie, any, unused_hi;
  logic [3:0] id;
  reg_idx_t idx;
  assign off = mem_addr - ADDR_BASE;
  assign sel = mem_valid & (mem_addr >= ADDR_BASE) & (off <= 16'(OFF_GIE)) & ~mem_addr[0];
  assign idx = reg_idx_t'(off[3:1]);
  assign go = (state == S_IDLE) & sel;
  assign we = go & |mem_wstrb;
  assign wm = {{8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign wv = mem_wdata & wm;
  assign mask_w = (16'(mask) & ~wm) | wv;
  assign mode_w = (16'(mode) & ~wm) | wv;
  assign w1c = (we && idx == R_PEND) ? wv[N_SRC-1:0] : '0;
  assign rise = irq & ~prev & mode;
  assign pend = (pend_e & mode) | (irq & ~mode);
  assign active = pend & mask;
  assign unused_hi = ^{mask_w, mode_w, wv, off};
  trap_prio_enc #(.N(N_SRC)) u_enc (.req(active), .any(any), .id(id));
  // read mux for the addressed register, unused high bits read as zero
  always_comb begin
    rd_val = idx == R_PEND ? 16'(pend) :
             idx == R_MASK ? 16'(mask) :
             idx == R_MODE ? 16'(mode) :
             idx == R_CAUSE ? cause :
             idx == R_GIE ? {15'h0, gie} : 16'h0;
  end
  // bus access FSM, register writes, edge capture and trap/ack handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= 16'h0;
      trap <= 1'b0;
      prev <= '0;
      pend_e <= '0;
      mask <= '0;
      mode <= '0;
      cause <= 16'h0;
      gie <= 1'b0;
    end else begin
      state <= go ? S_RESP : S_IDLE;
      mem_ready <= go;
      mem_rdata <= go ? rd_val : 16'h0;
      prev <= irq;
      pend_e <= ((pend_e & ~w1c) | rise) & mode;
      trap <= ~trap_ack & gie & any;
      if (we && idx == R_MASK) mask <= mask_w[N_SRC-1:0];
      if (we && idx == R_MODE) mode <= mode_w[N_SRC-1:0];
      if (we && idx == R_CAUSE) cause <= 16'h0;
      if (we && idx == R_GIE && mem_wstrb[0]) gie <= mem_wdata[0];
      if (trap_ack) begin
        gie <= 1'b0;
        cause <= any ? ((16'h1 << CAUSE_VALID) | 16'(id)) : 16'h0;
      end
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table plus hand sequences for trap_ctrl with 16 sources
module tb_trap_ctrl;
  logic clk = 0, rst_n = 0, trap, trap_ack = 0, mem_valid = 0, mem_ready;
  logic [15:0] irq = 0, mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [1:0] mem_wstrb = 0;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [15:0] a;
    logic [1:0]  s;
    logic [15:0] d;
    logic        rdy;
    logic        chk;
    logic [15:0] exp;
  } vec_t;
  vec_t tab[$];

  trap_ctrl #(.N_SRC(16), .ADDR_BASE(16'hFF00)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .trap(trap), .trap_ack(trap_ack),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic acc(input logic [15:0] a, input logic [1:0] s, input logic [15:0] d,
                     output logic [15:0] r, output logic rd);
    @(negedge clk);
    mem_valid = 1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    @(posedge clk); #1;
    rd = mem_ready; r = mem_rdata;
    mem_valid = 0; mem_wstrb = 0;
    @(posedge clk); #1;
    if (rd) check("ready_drop", {15'h0, mem_ready}, 16'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] r;
    logic rd;
    acc(a, 2'b11, d, r, rd);
    check("wr_ready", {15'h0, rd}, 16'h1);
  endtask

  task automatic rdchk(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] r;
    logic rd;
    acc(a, 2'b00, 16'h0, r, rd);
    check({name, "_ready"}, {15'h0, rd}, 16'h1);
    check(name, r, exp);
  endtask

  task automatic ack;
    @(negedge clk); trap_ack = 1;
    @(posedge clk); #1; trap_ack = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] r;
    logic rd;
    tab.push_back('{16'hFF00, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF02, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF04, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF06, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF08, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF02, 2'b11, 16'hFFFF, 1, 0, 16'h0000});
    tab.push_back('{16'hFF02, 2'b00, 16'h0000, 1, 1, 16'hFFFF});
    tab.push_back('{16'hFF02, 2'b01, 16'h0000, 1, 0, 16'h0000});
    tab.push_back('{16'hFF02, 2'b00, 16'h0000, 1, 1, 16'hFF00});
    tab.push_back('{16'hFF02, 2'b11, 16'h0000, 1, 0, 16'h0000});
    tab.push_back('{16'hFF02, 2'b10, 16'hAB00, 1, 0, 16'h0000});
    tab.push_back('{16'hFF02, 2'b00, 16'h0000, 1, 1, 16'hAB00});
    tab.push_back('{16'hFF04, 2'b11, 16'h1234, 1, 0, 16'h0000});
    tab.push_back('{16'hFF04, 2'b00, 16'h0000, 1, 1, 16'h1234});
    tab.push_back('{16'hFF04, 2'b11, 16'h0000, 1, 0, 16'h0000});
    tab.push_back('{16'hFF08, 2'b11, 16'hFFFF, 1, 0, 16'h0000});
    tab.push_back('{16'hFF08, 2'b00, 16'h0000, 1, 1, 16'h0001});
    tab.push_back('{16'hFF08, 2'b01, 16'h0000, 1, 0, 16'h0000});
    tab.push_back('{16'hFF08, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF0A, 2'b00, 16'h0000, 0, 1, 16'h0000});
    tab.push_back('{16'hFF03, 2'b00, 16'h0000, 0, 1, 16'h0000});
    tab.push_back('{16'hFF03, 2'b11, 16'hFFFF, 0, 1, 16'h0000});
    tab.push_back('{16'hFF0A, 2'b11, 16'h0000, 0, 1, 16'h0000});
    tab.push_back('{16'hFEFE, 2'b11, 16'h0000, 0, 1, 16'h0000});
    tab.push_back('{16'hFF02, 2'b00, 16'h0000, 1, 1, 16'hAB00});
    tab.push_back('{16'hFF06, 2'b11, 16'hFFFF, 1, 0, 16'h0000});
    tab.push_back('{16'hFF06, 2'b00, 16'h0000, 1, 1, 16'h0000});
    tab.push_back('{16'hFF02, 2'b11, 16'h0000, 1, 0, 16'h0000});
    repeat (3) @(posedge clk);
    #1;
    check("rst_trap", {15'h0, trap}, 16'h0);
    check("rst_ready", {15'h0, mem_ready}, 16'h0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < tab.size(); i++) begin
      acc(tab[i].a, tab[i].s, tab[i].d, r, rd);
      check($sformatf("vec%0d_ready", i), {15'h0, rd}, {15'h0, tab[i].rdy});
      if (tab[i].chk) check($sformatf("vec%0d_rdata", i), r, tab[i].exp);
    end
    // edge path on source 0
    wr(16'hFF04, 16'h0001); wr(16'hFF02, 16'h0001); wr(16'hFF08, 16'h0001);
    check("edge_idle", {15'h0, trap}, 16'h0);
    @(negedge clk); irq[0] = 1;
    @(posedge clk); #1;
    check("edge_lat1", {15'h0, trap}, 16'h0);
    @(negedge clk); irq[0] = 0;
    @(posedge clk); #1;
    check("edge_lat2", {15'h0, trap}, 16'h1);
    ack;
    check("ack_trap", {15'h0, trap}, 16'h0);
    rdchk("edge_cause", 16'hFF06, 16'h8000);
    rdchk("edge_gie", 16'hFF08, 16'h0000);
    rdchk("edge_pend", 16'hFF00, 16'h0001);
    wr(16'hFF00, 16'h0001);
    rdchk("edge_w1c", 16'hFF00, 16'h0000);
    // priority between sources 3 and 5
    wr(16'hFF04, 16'h0028); wr(16'hFF02, 16'h0028); wr(16'hFF08, 16'h0001);
    @(negedge clk); irq[3] = 1; irq[5] = 1;
    cyc(3);
    check("prio_trap", {15'h0, trap}, 16'h1);
    ack;
    rdchk("prio_cause3", 16'hFF06, 16'h8003);
    wr(16'hFF00, 16'h0008); wr(16'hFF08, 16'h0001);
    cyc(1);
    check("prio_retrap", {15'h0, trap}, 16'h1);
    ack;
    rdchk("prio_cause5", 16'hFF06, 16'h8005);
    @(negedge clk); irq[3] = 0; irq[5] = 0;
    wr(16'hFF00, 16'h0020);
    rdchk("prio_pend", 16'hFF00, 16'h0000);
    ack;
    rdchk("empty_ack_cause", 16'hFF06, 16'h0000);
    // level path on source 2
    wr(16'hFF04, 16'h0000); wr(16'hFF02, 16'h0004); wr(16'hFF08, 16'h0001);
    @(negedge clk); irq[2] = 1;
    cyc(2);
    check("lvl_trap", {15'h0, trap}, 16'h1);
    rdchk("lvl_pend", 16'hFF00, 16'h0004);
    wr(16'hFF00, 16'h0004);
    rdchk("lvl_w1c", 16'hFF00, 16'h0004);
    @(negedge clk); irq[2] = 0;
    @(posedge clk); #1;
    check("lvl_release", {15'h0, trap}, 16'h0);
    // ack beats a same-cycle GIE write
    @(negedge clk); irq[2] = 1;
    cyc(2);
    @(negedge clk);
    mem_valid = 1; mem_addr = 16'hFF08; mem_wstrb = 2'b01; mem_wdata = 16'h0001; trap_ack = 1;
    @(posedge clk); #1;
    mem_valid = 0; mem_wstrb = 0; trap_ack = 0;
    cyc(1);
    check("ackgie_trap", {15'h0, trap}, 16'h0);
    rdchk("ackgie_gie", 16'hFF08, 16'h0000);
    @(negedge clk); irq[2] = 0;
    // edge set beats same-cycle W1C
    wr(16'hFF04, 16'h0002); wr(16'hFF02, 16'h0000);
    @(negedge clk);
    mem_valid = 1; mem_addr = 16'hFF00; mem_wstrb = 2'b11; mem_wdata = 16'h0002; irq[1] = 1;
    @(posedge clk); #1;
    mem_valid = 0; mem_wstrb = 0;
    cyc(1);
    rdchk("coll_pend", 16'hFF00, 16'h0002);
    wr(16'hFF00, 16'h0002);
    rdchk("coll_clr", 16'hFF00, 16'h0000);
    @(negedge clk); irq[1] = 0;
    // reset in the middle of a trap
    wr(16'hFF04, 16'h0001); wr(16'hFF02, 16'h0001); wr(16'hFF08, 16'h0001);
    @(negedge clk); irq[0] = 1;
    @(negedge clk); irq[0] = 0;
    cyc(1);
    check("pre_rst_trap", {15'h0, trap}, 16'h1);
    @(negedge clk); rst_n = 0;
    #1;
    check("mid_rst_trap", {15'h0, trap}, 16'h0);
    @(negedge clk); rst_n = 1;
    rdchk("post_rst_mask", 16'hFF02, 16'h0000);
    rdchk("post_rst_mode", 16'hFF04, 16'h0000);
    rdchk("post_rst_pend", 16'hFF00, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
